// File: rtl/wb_stage_pkg.sv
// rtl/wb_stage_pkg.sv - shared load-type and result-select encodings for the write-back stage
package wb_stage_pkg;

   // Load width/extension encodings, shared with MEM-stage decode
   localparam logic [2:0] LOAD_LW  = 3'd0;
   localparam logic [2:0] LOAD_LB  = 3'd1;
   localparam logic [2:0] LOAD_LBU = 3'd2;
   localparam logic [2:0] LOAD_LH  = 3'd3;
   localparam logic [2:0] LOAD_LHU = 3'd4;

   // Result source selection; encoding 3 is an alias for the ALU result
   localparam logic [1:0] WB_SEL_ALU  = 2'd0;
   localparam logic [1:0] WB_SEL_LOAD = 2'd1;
   localparam logic [1:0] WB_SEL_LINK = 2'd2;

endpackage

// File: rtl/wb_load_align.sv
// rtl/wb_load_align.sv - aligns and extends data RAM read data for sub-word loads
module wb_load_align
   import wb_stage_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [2:0]  load_type,
   input  logic [1:0]  addr_lo,
   output logic [31:0] aligned
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Pick the addressed byte and half-word lanes; half-word ignores addr_lo[0]
   always_comb begin
      byte_sel = rdata[7:0];
      case (addr_lo)
         2'd0: byte_sel = rdata[7:0];
         2'd1: byte_sel = rdata[15:8];
         2'd2: byte_sel = rdata[23:16];
         2'd3: byte_sel = rdata[31:24];
         default: byte_sel = rdata[7:0];
      endcase
      half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
   end

   // Extend the selected lane; unknown load types behave as a full word
   always_comb begin
      aligned = rdata;
      case (load_type)
         LOAD_LB:  aligned = {{24{byte_sel[7]}}, byte_sel};
         LOAD_LBU: aligned = {24'd0, byte_sel};
         LOAD_LH:  aligned = {{16{half_sel[15]}}, half_sel};
         LOAD_LHU: aligned = {16'd0, half_sel};
         default:  aligned = rdata;
      endcase
   end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - MIPS write-back stage: capture from MEM, select result, drive GPR/forward/trace buses
module wb_stage
   import wb_stage_pkg::*;
#(
   parameter logic [31:0] PC_RESET = 32'hBFC0_0000,
   parameter int          CNT_W    = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             mem_to_wb_valid,
   output logic             wb_allowin,
   input  logic [31:0]      mem_pc,
   input  logic [31:0]      mem_alu_result,
   input  logic             mem_rf_wen,
   input  logic [4:0]       mem_rf_addr,
   input  logic [1:0]       mem_wb_sel,
   input  logic [2:0]       mem_load_type,
   input  logic [31:0]      dram_rdata,
   input  logic             ext_stall,
   output logic             rf_we,
   output logic [4:0]       rf_waddr,
   output logic [31:0]      rf_wdata,
   output logic             fwd_valid,
   output logic [4:0]       fwd_addr,
   output logic [31:0]      fwd_data,
   output logic [31:0]      debug_wb_pc,
   output logic             debug_wb_rf_wen,
   output logic [4:0]       debug_wb_rf_addr,
   output logic [31:0]      debug_wb_rf_wdata,
   output logic [CNT_W-1:0] retire_count
);

   logic        wb_valid;
   logic [31:0] wb_pc;
   logic [31:0] wb_alu;
   logic        wb_rf_wen;
   logic [4:0]  wb_rf_addr;
   logic [1:0]  wb_sel;
   logic [2:0]  wb_load_type;
   logic [1:0]  wb_addr_lo;

   logic        wb_ready_go;
   logic        retire;
   logic        dest_live;
   logic [31:0] load_data;
   logic [31:0] result;

   assign wb_ready_go = !ext_stall;
   assign wb_allowin  = !wb_valid || wb_ready_go;
   // Retirement is masked while reset is asserted so no write leaks out in the reset cycle
   assign retire      = wb_valid && wb_ready_go && reset;
   assign dest_live   = wb_rf_wen && (wb_rf_addr != 5'd0);

   // Pipeline register: capture from MEM, drain when empty input, hold on stall
   always_ff @(posedge clk) begin
      if (!reset) begin
         wb_valid     <= 1'b0;
         wb_pc        <= PC_RESET;
         wb_alu       <= 32'd0;
         wb_rf_wen    <= 1'b0;
         wb_rf_addr   <= 5'd0;
         wb_sel       <= 2'd0;
         wb_load_type <= 3'd0;
         wb_addr_lo   <= 2'd0;
      end else if (wb_allowin) begin
         wb_valid <= mem_to_wb_valid;
         if (mem_to_wb_valid) begin
            wb_pc        <= mem_pc;
            wb_alu       <= mem_alu_result;
            wb_rf_wen    <= mem_rf_wen;
            wb_rf_addr   <= mem_rf_addr;
            wb_sel       <= mem_wb_sel;
            wb_load_type <= mem_load_type;
            wb_addr_lo   <= mem_alu_result[1:0];
         end
      end
   end

   // Count retired instructions; wraps naturally at the counter width
   always_ff @(posedge clk) begin
      if (!reset) begin
         retire_count <= '0;
      end else if (retire) begin
         retire_count <= retire_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   wb_load_align u_load_align (
      .rdata     (dram_rdata),
      .load_type (wb_load_type),
      .addr_lo   (wb_addr_lo),
      .aligned   (load_data)
   );

   // Result select: ALU, aligned load data, or link address pc+8
   always_comb begin
      result = wb_alu;
      case (wb_sel)
         WB_SEL_LOAD: result = load_data;
         WB_SEL_LINK: result = wb_pc + 32'd8;
         default:     result = wb_alu;
      endcase
   end

   assign rf_we    = retire && dest_live;
   assign rf_waddr = wb_rf_addr;
   assign rf_wdata = result;

   // Forwarding stays up during a stall so ID can bypass the pending value
   assign fwd_valid = wb_valid && dest_live;
   assign fwd_addr  = wb_rf_addr;
   assign fwd_data  = result;

   assign debug_wb_pc       = wb_pc;
   assign debug_wb_rf_wen   = rf_we;
   assign debug_wb_rf_addr  = rf_waddr;
   assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - self-checking bench for wb_stage with a transaction-level reference model
`timescale 1ns/1ps
module tb_wb_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_to_wb_valid;
   logic        wb_allowin;
   logic [31:0] mem_pc;
   logic [31:0] mem_alu_result;
   logic        mem_rf_wen;
   logic [4:0]  mem_rf_addr;
   logic [1:0]  mem_wb_sel;
   logic [2:0]  mem_load_type;
   logic [31:0] dram_rdata;
   logic        ext_stall;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        fwd_valid;
   logic [4:0]  fwd_addr;
   logic [31:0] fwd_data;
   logic [31:0] debug_wb_pc;
   logic        debug_wb_rf_wen;
   logic [4:0]  debug_wb_rf_addr;
   logic [31:0] debug_wb_rf_wdata;
   logic [31:0] retire_count;

   int checks = 0;
   int errors = 0;

   // reference model: the instruction currently held in WB, plus retire count
   logic        m_valid;
   logic [31:0] m_pc, m_alu, m_cnt;
   logic        m_wen;
   logic [4:0]  m_addr;
   logic [1:0]  m_sel;
   logic [2:0]  m_lt;
   logic [1:0]  m_lo;

   always #5 clk = ~clk;

   wb_stage dut (
      .clk               (clk),
      .reset             (reset),
      .mem_to_wb_valid   (mem_to_wb_valid),
      .wb_allowin        (wb_allowin),
      .mem_pc            (mem_pc),
      .mem_alu_result    (mem_alu_result),
      .mem_rf_wen        (mem_rf_wen),
      .mem_rf_addr       (mem_rf_addr),
      .mem_wb_sel        (mem_wb_sel),
      .mem_load_type     (mem_load_type),
      .dram_rdata        (dram_rdata),
      .ext_stall         (ext_stall),
      .rf_we             (rf_we),
      .rf_waddr          (rf_waddr),
      .rf_wdata          (rf_wdata),
      .fwd_valid         (fwd_valid),
      .fwd_addr          (fwd_addr),
      .fwd_data          (fwd_data),
      .debug_wb_pc       (debug_wb_pc),
      .debug_wb_rf_wen   (debug_wb_rf_wen),
      .debug_wb_rf_addr  (debug_wb_rf_addr),
      .debug_wb_rf_wdata (debug_wb_rf_wdata),
      .retire_count      (retire_count)
   );

   // expected write data from the held instruction, using shifts and masks
   function automatic logic [31:0] model_wdata(input logic [31:0] rdata);
      logic [31:0] b, h;
      b = (rdata >> (8 * int'(m_lo))) & 32'h0000_00FF;
      h = (rdata >> (16 * int'(m_lo[1]))) & 32'h0000_FFFF;
      if (m_sel == 2'd2) return m_pc + 32'd8;
      if (m_sel != 2'd1) return m_alu;
      case (m_lt)
         3'd1:    return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
         3'd2:    return b;
         3'd3:    return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
         3'd4:    return h;
         default: return rdata;
      endcase
   endfunction

   // apply one clock edge of the transaction rules to the model
   task automatic model_edge();
      if (!reset) begin
         m_valid = 1'b0; m_pc = 32'hBFC0_0000; m_alu = 32'd0; m_wen = 1'b0;
         m_addr = 5'd0; m_sel = 2'd0; m_lt = 3'd0; m_lo = 2'd0; m_cnt = 32'd0;
      end else begin
         if (m_valid && !ext_stall) m_cnt = m_cnt + 32'd1;
         if (!m_valid || !ext_stall) begin
            m_valid = mem_to_wb_valid;
            if (mem_to_wb_valid) begin
               m_pc = mem_pc; m_alu = mem_alu_result; m_wen = mem_rf_wen;
               m_addr = mem_rf_addr; m_sel = mem_wb_sel; m_lt = mem_load_type;
               m_lo = mem_alu_result[1:0];
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic send(input logic [31:0] pc, input logic [31:0] alu, input logic wen,
                       input logic [4:0] addr, input logic [1:0] sel, input logic [2:0] lt);
      mem_to_wb_valid = 1'b1; mem_pc = pc; mem_alu_result = alu; mem_rf_wen = wen;
      mem_rf_addr = addr; mem_wb_sel = sel; mem_load_type = lt;
   endtask

   task automatic test_reset();
      reset = 1'b0; ext_stall = 1'b0; mem_to_wb_valid = 1'b0; dram_rdata = 32'd0;
      send(32'd0, 32'd0, 1'b0, 5'd0, 2'd0, 3'd0);
      mem_to_wb_valid = 1'b0;
      tick(); tick();
      reset = 1'b1;
      #1;
      checks++; if (wb_allowin !== 1'b1) begin errors++; $display("FAIL reset_allowin got %b exp 1", wb_allowin); end
      checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we got %b exp 0", rf_we); end
      checks++; if (fwd_valid !== 1'b0) begin errors++; $display("FAIL reset_fwd got %b exp 0", fwd_valid); end
      checks++; if (debug_wb_pc !== 32'hBFC0_0000) begin errors++; $display("FAIL reset_pc got %h exp bfc00000", debug_wb_pc); end
      checks++; if (retire_count !== 32'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", retire_count); end
   endtask

   task automatic test_alu_write();
      send(32'hBFC0_0000, 32'h0000_1234, 1'b1, 5'd8, 2'd0, 3'd0);
      tick();
      mem_to_wb_valid = 1'b0;
      #1;
      checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd8 || rf_wdata !== 32'h0000_1234)
         begin errors++; $display("FAIL alu_write got we=%b a=%0d d=%h exp we=1 a=8 d=00001234", rf_we, rf_waddr, rf_wdata); end
      checks++; if (debug_wb_rf_wen !== 1'b1 || debug_wb_rf_addr !== 5'd8 || debug_wb_rf_wdata !== 32'h0000_1234 || debug_wb_pc !== 32'hBFC0_0000)
         begin errors++; $display("FAIL alu_debug got wen=%b a=%0d d=%h pc=%h", debug_wb_rf_wen, debug_wb_rf_addr, debug_wb_rf_wdata, debug_wb_pc); end
      tick();
      checks++; if (retire_count !== 32'd1) begin errors++; $display("FAIL alu_count got %0d exp 1", retire_count); end
      checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL alu_drain got %b exp 0", rf_we); end
   endtask

   task automatic test_loads();
      logic [2:0]  lt_tab  [9] = '{3'd1, 3'd2, 3'd1, 3'd3, 3'd4, 3'd3, 3'd3, 3'd0, 3'd7};
      logic [1:0]  lo_tab  [9] = '{2'd3, 2'd3, 2'd0, 2'd2, 2'd2, 2'd0, 2'd3, 2'd1, 2'd2};
      logic [31:0] exp_tab [9] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_FFF3, 32'hFFFF_8091,
                                   32'h0000_8091, 32'hFFFF_A2F3, 32'hFFFF_8091, 32'h8091_A2F3, 32'h8091_A2F3};
      for (int i = 0; i < 9; i++) begin
         send(32'h0000_1000 + 32'(4 * i), {30'h0000_0100, lo_tab[i]}, 1'b1, 5'd9, 2'd1, lt_tab[i]);
         tick();
         mem_to_wb_valid = 1'b0;
         dram_rdata = 32'h8091_A2F3;
         #1;
         checks++; if (rf_wdata !== exp_tab[i] || rf_we !== 1'b1)
            begin errors++; $display("FAIL load_%0d type=%0d lo=%0d got %h we=%b exp %h", i, lt_tab[i], lo_tab[i], rf_wdata, rf_we, exp_tab[i]); end
         tick();
      end
   endtask

   task automatic test_link_and_zero();
      logic [31:0] cnt_before;
      send(32'hBFC0_0010, 32'hDEAD_BEEF, 1'b1, 5'd31, 2'd2, 3'd0);
      tick();
      send(32'hBFC0_0014, 32'h1111_2222, 1'b1, 5'd0, 2'd0, 3'd0);
      #1;
      checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd31 || rf_wdata !== 32'hBFC0_0018)
         begin errors++; $display("FAIL link got we=%b a=%0d d=%h exp we=1 a=31 d=bfc00018", rf_we, rf_waddr, rf_wdata); end
      tick();
      mem_to_wb_valid = 1'b0;
      cnt_before = m_cnt;
      #1;
      checks++; if (rf_we !== 1'b0 || fwd_valid !== 1'b0 || debug_wb_rf_wen !== 1'b0)
         begin errors++; $display("FAIL zero_reg got we=%b fwd=%b dbg=%b exp 0", rf_we, fwd_valid, debug_wb_rf_wen); end
      tick();
      checks++; if (retire_count !== cnt_before + 32'd1)
         begin errors++; $display("FAIL zero_reg_count got %0d exp %0d", retire_count, cnt_before + 32'd1); end
   endtask

   task automatic test_stall();
      send(32'h0000_0100, 32'h0000_00AA, 1'b1, 5'd5, 2'd0, 3'd0);
      tick();
      ext_stall = 1'b1;
      send(32'h0000_0200, 32'h0000_00BB, 1'b1, 5'd6, 2'd0, 3'd0);
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (wb_allowin !== 1'b0 || rf_we !== 1'b0 || fwd_valid !== 1'b1 || fwd_addr !== 5'd5 || fwd_data !== 32'h0000_00AA || debug_wb_pc !== 32'h0000_0100)
            begin errors++; $display("FAIL stall_%0d got alw=%b we=%b fwd=%b fa=%0d fd=%h pc=%h", i, wb_allowin, rf_we, fwd_valid, fwd_addr, fwd_data, debug_wb_pc); end
         tick();
      end
      ext_stall = 1'b0;
      #1;
      checks++; if (wb_allowin !== 1'b1 || rf_we !== 1'b1 || rf_wdata !== 32'h0000_00AA)
         begin errors++; $display("FAIL stall_release got alw=%b we=%b d=%h exp 1 1 000000aa", wb_allowin, rf_we, rf_wdata); end
      tick();
      mem_to_wb_valid = 1'b0;
      #1;
      checks++; if (debug_wb_pc !== 32'h0000_0200 || rf_we !== 1'b1 || rf_waddr !== 5'd6 || rf_wdata !== 32'h0000_00BB)
         begin errors++; $display("FAIL stall_next got pc=%h we=%b a=%0d d=%h", debug_wb_pc, rf_we, rf_waddr, rf_wdata); end
      tick();
   endtask

   task automatic test_back_to_back_random();
      logic        e_we, e_fwd, e_alw;
      logic [31:0] e_d;
      for (int i = 0; i < 400; i++) begin
         mem_to_wb_valid = ($urandom_range(0, 3) != 0);
         ext_stall       = ($urandom_range(0, 3) == 0);
         mem_pc          = $urandom;
         mem_alu_result  = $urandom;
         mem_rf_wen      = 1'($urandom);
         mem_rf_addr     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
         mem_wb_sel      = 2'($urandom);
         mem_load_type   = 3'($urandom);
         dram_rdata      = $urandom;
         #1;
         e_alw = !m_valid || !ext_stall;
         e_fwd = m_valid && m_wen && (m_addr != 5'd0);
         e_we  = e_fwd && !ext_stall;
         e_d   = model_wdata(dram_rdata);
         checks++; if (wb_allowin !== e_alw || rf_we !== e_we || fwd_valid !== e_fwd || debug_wb_rf_wen !== e_we)
            begin errors++; $display("FAIL rnd_%0d_ctl got alw=%b we=%b fwd=%b exp alw=%b we=%b fwd=%b", i, wb_allowin, rf_we, fwd_valid, e_alw, e_we, e_fwd); end
         checks++; if (debug_wb_pc !== m_pc || retire_count !== m_cnt)
            begin errors++; $display("FAIL rnd_%0d_pc got pc=%h cnt=%0d exp pc=%h cnt=%0d", i, debug_wb_pc, retire_count, m_pc, m_cnt); end
         if (e_fwd) begin
            checks++; if (rf_waddr !== m_addr || rf_wdata !== e_d || fwd_addr !== m_addr || fwd_data !== e_d || debug_wb_rf_wdata !== e_d)
               begin errors++; $display("FAIL rnd_%0d_data got a=%0d d=%h exp a=%0d d=%h", i, rf_waddr, rf_wdata, m_addr, e_d); end
         end
         tick();
      end
      ext_stall = 1'b0;
      mem_to_wb_valid = 1'b0;
   endtask

   task automatic test_reset_mid();
      send(32'h0000_0300, 32'h0000_00CC, 1'b1, 5'd7, 2'd0, 3'd0);
      tick();
      mem_to_wb_valid = 1'b0;
      reset = 1'b0;
      #1;
      checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL rst_mid_cycle got we=%b exp 0", rf_we); end
      tick();
      reset = 1'b1;
      #1;
      checks++; if (rf_we !== 1'b0 || fwd_valid !== 1'b0 || debug_wb_pc !== 32'hBFC0_0000 || retire_count !== 32'd0)
         begin errors++; $display("FAIL rst_mid_after got we=%b fwd=%b pc=%h cnt=%0d", rf_we, fwd_valid, debug_wb_pc, retire_count); end
      tick();
   endtask

   initial begin
      test_reset();
      test_alu_write();
      test_loads();
      test_link_and_zero();
      test_stall();
      test_back_to_back_random();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
